// File: rtl/uart_tx_scheduler_pkg.sv
// rtl/uart_tx_scheduler_pkg.sv - shared types, constants and helpers for the UART TX scheduler
package uart_tx_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_ARB       = 2'd0,
    ST_WAIT_DONE = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_GAP       = 2'd3
  } sched_state_e;

  // State codes of the downstream uart_transmitter, kept here so both blocks share one view.
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned DEFAULT_GAP_TICKS      = 1;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 100000;

  // Bits needed to hold values 0..value-1, never less than one.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width = 1;
    while ((64'd1 << width) < 64'(value)) width++;
    return width;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// rtl/uart_tx_scheduler_if.sv - source and transmitter handshake bundle of the UART TX scheduler
interface uart_tx_scheduler_if
  import uart_tx_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned GW = clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid_p;
  logic [8*N_REQ-1:0] req_data_p;
  logic [N_REQ-1:0]   req_ready_p;
  logic               baud_1_x_p;
  logic               transmit_req_p;
  logic [7:0]         transmit_data_p;
  logic               transmit_done_p;
  logic [GW-1:0]      grant_id_p;
  logic               busy_p;
  logic               timeout_err_p;

  modport master (
    input  req_valid_p, req_data_p, baud_1_x_p, transmit_done_p,
    output req_ready_p, transmit_req_p, transmit_data_p, grant_id_p, busy_p, timeout_err_p
  );

  modport slave (
    output req_valid_p, req_data_p, baud_1_x_p, transmit_done_p,
    input  req_ready_p, transmit_req_p, transmit_data_p, grant_id_p, busy_p, timeout_err_p
  );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// rtl/uart_tx_scheduler_rr_arbiter.sv - combinational round-robin pick: first valid index after the pointer
module uart_tx_scheduler_rr_arbiter
  import uart_tx_scheduler_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned GW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [GW-1:0]    ptr_i,
  output logic [GW-1:0]    winner_o,
  output logic             any_valid_o
);

  int unsigned idx;

  always_comb begin
    winner_o    = '0;
    any_valid_o = 1'b0;
    idx         = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(ptr_i) + k) % N_REQ;
      if (!any_valid_o && valid_i[idx]) begin
        any_valid_o = 1'b1;
        winner_o    = idx[GW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin sharing of one uart_transmitter with req/done handshake,
// baud-tick idle gap and request watchdog
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned GAP_TICKS      = DEFAULT_GAP_TICKS,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic                 clk210_p,
  input logic                 reset_n_p,
  uart_tx_scheduler_if.master bus
);

  localparam int unsigned GW    = clog2(N_REQ);
  localparam int unsigned GAP_W = clog2(GAP_TICKS + 1);
  localparam int unsigned WD_W  = clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_TICKS == 0) ? 0 : GAP_TICKS - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  sched_state_e     state_q, state_d;
  logic [GW-1:0]    ptr_q, ptr_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [7:0]       data_q, data_d;
  logic             req_q, req_d;
  logic [N_REQ-1:0] ready_q, ready_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             tmo_q, tmo_d;

  logic [GW-1:0]    arb_winner;
  logic             arb_any;
  logic             wd_expired;

  uart_tx_scheduler_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .valid_i     (bus.req_valid_p),
    .ptr_i       (ptr_q),
    .winner_o    (arb_winner),
    .any_valid_o (arb_any)
  );

  // wd_q counts completed request cycles, so expiry lands on the TIMEOUT_CYCLES-th cycle.
  assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST);

  always_ff @(posedge clk210_p or negedge reset_n_p) begin
    if (!reset_n_p) begin
      state_q <= ST_ARB;
      ptr_q   <= GW'(N_REQ - 1);
      grant_q <= '0;
      data_q  <= '0;
      req_q   <= 1'b0;
      ready_q <= '0;
      gap_q   <= '0;
      wd_q    <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      req_q   <= req_d;
      ready_q <= ready_d;
      gap_q   <= gap_d;
      wd_q    <= wd_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    req_d   = req_q;
    ready_d = '0;
    gap_d   = gap_q;
    wd_d    = wd_q;
    tmo_d   = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (arb_any) begin
          data_d              = bus.req_data_p[{arb_winner, 3'b000} +: 8];
          grant_d             = arb_winner;
          ptr_d               = arb_winner;
          ready_d[arb_winner] = 1'b1;
          req_d               = 1'b1;
          wd_d                = '0;
          state_d             = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        // done is tested first so a done coinciding with expiry is not an error
        if (bus.transmit_done_p) begin
          req_d   = 1'b0;
          state_d = ST_RELEASE;
        end else if (wd_expired) begin
          req_d   = 1'b0;
          tmo_d   = 1'b1;
          gap_d   = '0;
          state_d = ST_GAP;
        end
        if (TIMEOUT_CYCLES != 0) wd_d = wd_q + 1'b1;
      end
      ST_RELEASE: begin
        if (!bus.transmit_done_p) begin
          gap_d   = '0;
          state_d = ST_GAP;
        end else if (wd_expired) begin
          tmo_d   = 1'b1;
          gap_d   = '0;
          state_d = ST_GAP;
        end
        if (TIMEOUT_CYCLES != 0) wd_d = wd_q + 1'b1;
      end
      ST_GAP: begin
        if (GAP_TICKS == 0) begin
          state_d = ST_ARB;
        end else if (bus.baud_1_x_p) begin
          if (gap_q == GAP_LAST) state_d = ST_ARB;
          else                   gap_d   = gap_q + 1'b1;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  assign bus.req_ready_p     = ready_q;
  assign bus.transmit_req_p  = req_q;
  assign bus.transmit_data_p = data_q;
  assign bus.grant_id_p      = grant_q;
  assign bus.busy_p          = (state_q != ST_ARB);
  assign bus.timeout_err_p   = tmo_q;

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one uart_transmitter between N_REQ byte sources using round-robin arbitration.
- Runs the transmitter's req/done handshake: assert request, wait for done, release, wait for done to clear.
- Enforces a minimum stop/idle gap, counted in baud ticks, between bytes.
- Sits between the telemetry/command producers and the single UART TX pin path, in the clk210 domain.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- GAP_TICKS, 1, baud_1_x ticks of line idle enforced after each byte (0 = no gap).
- TIMEOUT_CYCLES, 100000, clk210 cycles allowed from request to done release (0 = watchdog disabled).

Ports:
- clk210_p  in  1  system clock, 210 MHz
- reset_n_p  in  1  asynchronous active-low reset
- req_valid_p  in  N_REQ  per-source byte-available flag
- req_data_p  in  8*N_REQ  per-source byte; source i uses bits [8i+7:8i]
- req_ready_p  out  N_REQ  one-cycle accept pulse per source
- baud_1_x_p  in  1  1x baud strobe, one clk wide (same strobe that feeds the transmitter)
- transmit_req_p  out  1  to transmitter transmit_req
- transmit_data_p  out  8  to transmitter transmit_data
- transmit_done_p  in  1  from transmitter transmit_done
- grant_id_p  out  clog2(N_REQ)  index of the source currently or last served
- busy_p  out  1  high in any state other than ARB
- timeout_err_p  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async assert, sync-released use): state=ARB. All outputs are 0. The round-robin pointer is N_REQ-1, so source 0 has first priority. Counters are cleared.
- The transmitter's own reset must come from the same reset source. Reset asserted mid-byte drops transmit_req_p immediately; the byte is lost and ready is not re-issued.
- States: ARB, WAIT_DONE, RELEASE, GAP.
- ARB:
  - If any valid is high at the clock edge, select the first valid index after the pointer (wrapping).
  - On that edge: capture its byte into transmit_data_p, set grant_id_p, update the pointer to the winner, drive req_ready_p[winner]=1 for exactly the next cycle, and set transmit_req_p=1. Next state is WAIT_DONE.
  - Latency: transmit_req_p is high in the cycle after the accepting edge.
  - If no valid is high, stay in ARB with all outputs idle.
- Source rule: hold valid/data stable until ready is seen. A source may drop valid before ready; the drop is honoured only if it occurs before an accepting edge.
- WAIT_DONE: hold transmit_req_p=1 and transmit_data_p stable. On transmit_done_p=1, clear transmit_req_p and go to RELEASE.
- RELEASE: transmit_req_p=0. On transmit_done_p=0, clear the gap counter and go to GAP.
- GAP:
  - Count baud_1_x_p pulses. When the count reaches GAP_TICKS, go to ARB.
  - With GAP_TICKS=0, go straight to ARB after one cycle.
  - The gap counter width is clog2(GAP_TICKS+1), minimum 1 bit.
- Watchdog (TIMEOUT_CYCLES>0):
  - The counter clears on entry to WAIT_DONE and increments every cycle in WAIT_DONE and RELEASE.
  - On reaching TIMEOUT_CYCLES: transmit_req_p=0, timeout_err_p pulses 1 cycle, go to GAP. The grant pointer is still advanced.
  - If done and expiry coincide, done wins and there is no error.
- Fairness: a source that is continuously valid waits at most N_REQ-1 other bytes.
- transmit_data_p changes only on an ARB accept edge.

Decomposition:
- Shared package holds:
  - state encodings (2-bit: ARB=0, WAIT_DONE=1, RELEASE=2, GAP=3);
  - clog2 function;
  - default GAP_TICKS/TIMEOUT_CYCLES constants, alongside the transmitter's TX state codes.
- One natural sub-module, rr_arbiter: combinational next-winner from valid vector plus pointer, with an any_valid output. It is reusable for future shared-resource schedulers.

Test Plan:
- Single source: valid[0]=1, data 0xA5; transmitter model done after 10 baud ticks -> ready[0] pulses once, the cycle after accept. transmit_req high from the next cycle until done, transmit_data=0xA5, grant_id=0.
- Contention: valid[0..2]=1 continuously, data 0x11/0x22/0x33 -> TX order 0x11, 0x22, 0x33, 0x11. Exactly one ready per byte, in the same order.
- Gap: GAP_TICKS=2 with back-to-back bytes -> the next transmit_req rises only after 2 baud_1_x pulses following done falling. With GAP_TICKS=0, ARB is reached one cycle after RELEASE exits.
- Timeout: TIMEOUT_CYCLES=50, done held 0 -> transmit_req drops at cycle 50 of the request, timeout_err pulses once, then GAP and the next source served. Done rising at cycle 50 exactly -> no error.
- Reset mid-byte: assert reset_n_p=0 during WAIT_DONE -> transmit_req, busy, ready, and grant_id are 0 immediately. After release, source 0 has priority.
- Withdrawn request: valid[1] high and dropped before any accept edge while busy -> no ready[1] and no byte sent for source 1.
